// File: rtl/dma_read_tlp.sv
// Splits a DMA read job into MRd descriptors that never cross an MRRS-aligned
// boundary, fetching one tag from the tag manager per descriptor.
module dma_read_tlp #(
  parameter int MRRS_DW = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req_vld,
  output logic        rd_req_rdy,
  input  logic [63:0] rd_req_addr,
  input  logic [15:0] rd_req_len,
  output logic        tag_read_req,
  output logic        tag_read_last,
  input  logic        tag_read_ack,
  input  logic [4:0]  tag_read_number,
  output logic        mrd_vld,
  input  logic        mrd_rdy,
  output logic [63:0] mrd_addr,
  output logic [10:0] mrd_len,
  output logic [4:0]  mrd_tag,
  output logic        mrd_last,
  output logic        rd_done
);

  localparam int OFS_W = $clog2(MRRS_DW);

  generate
    if (MRRS_DW != 32 && MRRS_DW != 64 && MRRS_DW != 128 &&
        MRRS_DW != 256 && MRRS_DW != 512 && MRRS_DW != 1024) begin : g_bad_mrrs
      $error("dma_read_tlp: illegal MRRS_DW");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, CALC, TAG_REQ, ISSUE, DONE} state_t;

  typedef struct packed {
    logic [61:0] addr;   // DW address of the next MRd
    logic [10:0] len;
    logic [4:0]  tag;
    logic        last;
  } mrd_desc_t;

  state_t      state, state_nxt;
  mrd_desc_t   desc;
  logic [15:0] rem;
  logic        rdy_q;
  logic        unused_addr_lsb;

  logic [10:0] ofs, room, chunk;

  assign unused_addr_lsb = ^rd_req_addr[1:0];

  // Room left before the next MRRS-aligned boundary; MRRS <= 4KB so this
  // also keeps every MRd inside its 4KB page.
  assign ofs   = 11'(desc.addr[OFS_W-1:0]);
  assign room  = 11'(MRRS_DW) - ofs;
  assign chunk = (rem < 16'(room)) ? rem[10:0] : room;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_req_vld && rdy_q) state_nxt = (rd_req_len == 16'd0) ? DONE : CALC;
      CALC:    state_nxt = TAG_REQ;
      TAG_REQ: if (tag_read_ack) state_nxt = ISSUE;
      ISSUE:   if (mrd_rdy) state_nxt = desc.last ? DONE : CALC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rdy is registered so it stays low while reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      desc <= '0;
      rem  <= '0;
    end else begin
      case (state)
        IDLE: if (rd_req_vld && rdy_q) begin
          desc.addr <= rd_req_addr[63:2];
          rem       <= rd_req_len;
        end
        CALC: begin
          desc.len  <= chunk;
          desc.last <= (rem == 16'(chunk));
        end
        TAG_REQ: if (tag_read_ack) desc.tag <= tag_read_number;
        ISSUE: if (mrd_rdy) begin
          desc.addr <= desc.addr + 62'(desc.len);
          rem       <= rem - 16'(desc.len);
        end
        default: ;
      endcase
    end
  end

  assign rd_req_rdy    = rdy_q;
  assign tag_read_req  = (state == TAG_REQ);
  assign tag_read_last = tag_read_req & desc.last;
  assign mrd_vld       = (state == ISSUE);
  assign mrd_addr      = {desc.addr, 2'b00};
  assign mrd_len       = desc.len;
  assign mrd_tag       = desc.tag;
  assign mrd_last      = desc.last;
  assign rd_done       = (state == DONE);

endmodule

// File: tb/tb_dma_read_tlp.sv
// Randomized bench for dma_read_tlp: a split model computes the expected MRd
// list per job, a tag manager and MRd sink apply random back-pressure.
module tb_dma_read_tlp;
  localparam int MRRS = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req_vld;
  logic        rd_req_rdy;
  logic [63:0] rd_req_addr;
  logic [15:0] rd_req_len;
  logic        tag_read_req, tag_read_last, tag_read_ack;
  logic [4:0]  tag_read_number;
  logic        mrd_vld, mrd_rdy;
  logic [63:0] mrd_addr;
  logic [10:0] mrd_len;
  logic [4:0]  mrd_tag;
  logic        mrd_last;
  logic        rd_done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] addr;
    int          len;
    bit          last;
  } exp_t;
  exp_t exp_q[$];

  dma_read_tlp #(.MRRS_DW(MRRS)) dut (
    .clk(clk), .rst(rst),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
    .tag_read_req(tag_read_req), .tag_read_last(tag_read_last),
    .tag_read_ack(tag_read_ack), .tag_read_number(tag_read_number),
    .mrd_vld(mrd_vld), .mrd_rdy(mrd_rdy),
    .mrd_addr(mrd_addr), .mrd_len(mrd_len), .mrd_tag(mrd_tag), .mrd_last(mrd_last),
    .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected MRds: cut at every MRRS-aligned boundary, addresses wrap at 2^64.
  function automatic void build_model(input logic [63:0] a_in, input int len);
    logic [63:0] a;
    int rem, room, c;
    exp_t e;
    exp_q.delete();
    a = a_in & ~64'd3;
    rem = len;
    while (rem > 0) begin
      room = MRRS - int'((a >> 2) % MRRS);
      c = (rem < room) ? rem : room;
      rem -= c;
      e.addr = a; e.len = c; e.last = (rem == 0);
      exp_q.push_back(e);
      a = a + 64'(c) * 64'd4;
    end
  endfunction

  // tag_dly / rdy_dly < 0 select random back-pressure, else a fixed stall.
  task automatic run_job(input logic [63:0] a, input int len, input int tag_dly, input int rdy_dly);
    int acc_cyc = -1, rise_cyc = 0, ack_cyc = 0, done_cyc = 0;
    int idx = 0, gidx = 0, req_run = 0, vld_run = 0, done_cnt = 0, tdly;
    bit accepted = 0;
    logic [4:0] grants[$];
    logic [63:0] p_addr;
    logic [16:0] p_fields;
    build_model(a, len);
    tdly = (tag_dly < 0) ? int'($urandom_range(0, 3)) : tag_dly;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      rd_req_vld = !accepted;
      rd_req_addr = a;
      rd_req_len = 16'(len);
      tag_read_ack = tag_read_req && (req_run >= tdly);
      tag_read_number = 5'($urandom);
      if (rdy_dly < 0) mrd_rdy = ($urandom_range(0, 2) != 0);
      else mrd_rdy = (vld_run >= rdy_dly);
      @(negedge clk);
      if (rd_req_vld && rd_req_rdy) begin accepted = 1; acc_cyc = cyc; end
      if (tag_read_req) begin
        if (req_run == 0) rise_cyc = cyc;
        req_run++;
        chk("req_excl_vld", mrd_vld, 0);
        if (tag_read_ack) begin
          chk("tag_last", tag_read_last, (gidx == exp_q.size() - 1));
          if (tag_dly >= 0) chk("req_hold", req_run, tag_dly + 1);
          grants.push_back(tag_read_number);
          gidx++; ack_cyc = cyc; req_run = 0;
          tdly = (tag_dly < 0) ? int'($urandom_range(0, 3)) : tag_dly;
        end
      end
      if (mrd_vld) begin
        if (vld_run > 0) begin
          chk("stable_addr", mrd_addr, p_addr);
          chk("stable_fields", {mrd_len, mrd_tag, mrd_last}, p_fields);
        end else if (idx == 0) begin
          chk("first_latency", cyc - acc_cyc, 2 + (ack_cyc - rise_cyc + 1));
        end
        if (mrd_rdy) begin
          if (idx < exp_q.size()) begin
            chk("mrd_addr", mrd_addr, exp_q[idx].addr);
            chk("mrd_len", mrd_len, exp_q[idx].len);
            chk("mrd_tag", mrd_tag, grants[idx]);
            chk("mrd_last", mrd_last, exp_q[idx].last);
          end else chk("extra_mrd", idx, exp_q.size());
          idx++; vld_run = 0;
        end else begin
          vld_run++;
          p_addr = mrd_addr;
          p_fields = {mrd_len, mrd_tag, mrd_last};
        end
      end
      if (rd_done) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
      end
      if (done_cnt > 0 && cyc > done_cyc + 2) break;
    end
    rd_req_vld = 0; tag_read_ack = 0; mrd_rdy = 0;
    if (done_cnt == 0) chk("job_timeout", 0, 1);
    chk("mrd_count", idx, exp_q.size());
    chk("grant_count", gidx, exp_q.size());
    chk("done_count", done_cnt, 1);
    if (len == 0) chk("zero_len_done_lat", (done_cyc - acc_cyc) inside {[1:2]}, 1);
  endtask

  task automatic reset_mid_job();
    bit seen = 0;
    build_model(64'h0, 300);
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      @(posedge clk); #1;
      rd_req_vld = (cyc == 0);
      rd_req_addr = 64'h0;
      rd_req_len = 16'd300;
      tag_read_ack = tag_read_req;
      tag_read_number = 5'($urandom);
      mrd_rdy = 0;
      @(negedge clk);
      seen = mrd_vld;
    end
    chk("reached_issue", seen, 1);
    rd_req_vld = 0;
    #2 rst = 0;
    tag_read_ack = 1;
    #1;
    chk("rst_mrd_vld", mrd_vld, 0);
    chk("rst_rdy", rd_req_rdy, 0);
    chk("rst_tag_req", tag_read_req, 0);
    @(negedge clk); @(negedge clk);
    rst = 1;
    mrd_rdy = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk("post_rst_rdy", rd_req_rdy, 1);
      chk("post_rst_no_req", tag_read_req, 0);
      chk("post_rst_no_mrd", mrd_vld, 0);
    end
    tag_read_ack = 0; mrd_rdy = 0;
  endtask

  initial begin
    logic [63:0] a;
    int l;
    rst = 0; rd_req_vld = 0; rd_req_addr = '0; rd_req_len = '0;
    tag_read_ack = 0; tag_read_number = '0; mrd_rdy = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {rd_req_rdy, tag_read_req, tag_read_last, mrd_vld, mrd_last, rd_done}, 0);
    chk("reset_desc", {mrd_addr ^ 64'h0, 11'(mrd_len), mrd_tag} == '0, 1);
    rst = 1;
    @(negedge clk); @(negedge clk);
    chk("release_rdy", rd_req_rdy, 1);

    run_job(64'h1000_0F80, 100, -1, -1);
    run_job(64'h0, 300, -1, -1);
    run_job(64'h0, 300, 0, 0);
    run_job(64'h1234_0000, 0, -1, -1);
    run_job(64'h0000_0040_0000_0100, 64, 20, 5);
    run_job(64'hFFFF_FFFF_FFFF_FF00, 200, -1, -1);
    run_job(64'h0000_0000_0000_01FF, 1, -1, -1);
    for (int j = 0; j < 25; j++) begin
      a = {$urandom, $urandom};
      l = (j % 3 == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(1, 1500));
      run_job(a, l, -1, -1);
    end
    reset_mid_job();
    run_job(64'h2000_0010, 260, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
